// File: rtl/visuaudio_pkg.sv
// Shared types and helpers for the visuaudio capture path.
// Sample type, reader states and saturating magnitude.
package visuaudio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } rd_state_t;

  function automatic logic [15:0] abs_sat16(input sample_t s);
    logic [15:0] u;
    u = s;
    if (u == 16'h8000)
      return 16'h7FFF;
    return s[15] ? (~u + 16'd1) : u;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of sample storage with write port,
// combinational read and running peak magnitude.
module frame_bank
  import visuaudio_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              i_BCLK,
  input  logic              i_rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sample_t           wdata,
  input  logic [ADDR_W-1:0] raddr,
  output sample_t           rdata,
  output logic [15:0]       peak
);

  sample_t     mem [FRAME_LEN];
  logic [15:0] mag;

  assign mag   = abs_sat16(wdata);
  assign rdata = mem[raddr];

  always_ff @(posedge i_BCLK) begin
    if (we)
      mem[waddr] <= wdata;
  end

  // index 0 reloads so a new frame never inherits the old peak
  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n)
      peak <= '0;
    else if (we && (waddr == '0 || mag > peak))
      peak <= mag;
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer between ADC capture and visualiser.
// Two banks, per-bank full flags, streaming reader FSM.
module audio_frame_buffer
  import visuaudio_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic        i_BCLK,
  input  logic        i_rst_n,
  input  sample_t     i_sample,
  input  logic        i_sample_valid,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output sample_t     o_rd_data,
  output logic        o_rd_last,
  output logic [15:0] o_rd_peak,
  output logic        o_overflow,
  output logic [15:0] o_drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

  rd_state_t         state, state_n;
  logic [1:0]        full;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_ok, wr_wrap, drop;
  logic              enter, rd_adv, rel;
  sample_t           bank_rdata [2];
  logic [15:0]       bank_peak  [2];

  assign wr_ok   = i_sample_valid && !full[wr_bank];
  assign wr_wrap = wr_ok && (wr_ptr == LAST);
  assign drop    = i_sample_valid && full[wr_bank];
  assign enter   = (state == R_IDLE) && full[rd_bank];
  assign rd_adv  = o_rd_valid && i_rd_ready;
  assign rel     = rd_adv && o_rd_last;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    frame_bank #(
      .FRAME_LEN(FRAME_LEN),
      .ADDR_W   (ADDR_W)
    ) u_bank (
      .i_BCLK (i_BCLK),
      .i_rst_n(i_rst_n),
      .we     (wr_ok && (wr_bank == 1'(g))),
      .waddr  (wr_ptr),
      .wdata  (i_sample),
      .raddr  (rd_ptr),
      .rdata  (bank_rdata[g]),
      .peak   (bank_peak[g])
    );
  end

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= R_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    o_rd_valid = 1'b0;
    o_rd_data  = '0;
    o_rd_last  = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (full[rd_bank])
          state_n = R_STREAM;
      end
      R_STREAM: begin
        o_rd_valid = 1'b1;
        o_rd_data  = bank_rdata[rd_bank];
        o_rd_last  = (rd_ptr == LAST);
        if (i_rd_ready && o_rd_last)
          state_n = R_IDLE;
      end
    endcase
  end

  // writer and reader never own the same full bit at once
  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (wr_wrap) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (rel)
        full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      o_rd_peak <= '0;
    end else if (enter) begin
      rd_ptr    <= '0;
      o_rd_peak <= bank_peak[rd_bank];
    end else if (rel) begin
      rd_bank <= ~rd_bank;
    end else if (rd_adv) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_overflow <= drop;
      if (drop && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: doc/audio_frame_buffer.md
# audio_frame_buffer

Ping-pong frame buffer directly downstream of the ADC capture controller. Collects the controller's 16-bit left-channel samples, one per single-cycle `done` pulse, into frames of `FRAME_LEN` samples. Streams each completed frame to the visualiser stage over a valid/ready handshake, together with the frame's peak magnitude. Runs on the codec bit clock so the ADC outputs connect without synchronisers.

## Interface
- `FRAME_LEN`, 64: samples per frame; power of two, 4..256.
- `ADDR_W`, $clog2(FRAME_LEN): pointer width; derived, do not override.
- `i_BCLK`  in  1  codec bit clock; the only clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_sample`  in  16  signed two's-complement sample (ADC `o_DATA`).
- `i_sample_valid`  in  1  one-cycle strobe (ADC `o_done`); `i_sample` is valid in the same cycle.
- `o_rd_valid`  out  1  `o_rd_data` holds a frame sample.
- `i_rd_ready`  in  1  consumer accepts the sample.
- `o_rd_data`  out  16  current frame sample.
- `o_rd_last`  out  1  the current sample is index FRAME_LEN-1.
- `o_rd_peak`  out  16  peak |sample| of the streaming frame; stable for the whole frame.
- `o_overflow`  out  1  one-cycle pulse when an input sample is dropped.
- `o_drop_cnt`  out  16  total dropped samples; saturates at 16'hFFFF.

## Operation
- Storage: two banks of FRAME_LEN x 16 flops. Per-bank `full` flag and per-bank running peak.
- Writer (always active): bank `wr_bank` with pointer `wr_ptr`.
  - On `i_sample_valid` with `full[wr_bank]`=0: store the sample at `wr_ptr` and increment `wr_ptr`. Set `peak[wr_bank]` = max(peak, abs(sample)).
  - abs: |-32768| saturates to 32767.
  - The first sample of a frame loads the peak directly; no stale peak carries over.
  - When `wr_ptr`==FRAME_LEN-1 on a write: set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_ptr` to 0.
  - On `i_sample_valid` with `full[wr_bank]`=1: drop the sample, pulse `o_overflow`, and increment `o_drop_cnt` (saturating). Neither pointer changes.
- Reader FSM, states R_IDLE and R_STREAM:
  - R_IDLE: `o_rd_valid`=0. If `full[rd_bank]`: go to R_STREAM, set `rd_ptr`=0, and latch `o_rd_peak` = `peak[rd_bank]`.
  - R_STREAM: `o_rd_valid`=1, `o_rd_data`=`bank[rd_bank][rd_ptr]` (combinational from flops), `o_rd_last`=(`rd_ptr`==FRAME_LEN-1).
    - On valid&ready and not last: increment `rd_ptr`.
    - On valid&ready and last: clear `full[rd_bank]`, toggle `rd_bank`, return to R_IDLE.
  - `o_rd_data` and `o_rd_last` are held while `i_rd_ready`=0.
- Simultaneous events:
  - Writer completing bank A in the same cycle the reader releases bank B: both updates apply. They never touch the same `full` bit.
  - A sample arriving in the release cycle of the bank the writer is blocked on is still dropped. The freed bank accepts from the next cycle.
- Reset (async, any time): clear `full` flags, pointers, peaks, and the drop count. Set `wr_bank`=`rd_bank`=0 and the FSM to R_IDLE. A partial frame is discarded.

## Timing
- Reset values: `o_rd_valid`=0, `o_rd_data`=0, `o_rd_last`=0, `o_rd_peak`=0, `o_overflow`=0, `o_drop_cnt`=0.
- Latency, last sample written to first read: `full` sets at edge N, the FSM enters R_STREAM at edge N+1, and `o_rd_valid` is high after edge N+1.
- Throughput: one sample per cycle while ready. There is one R_IDLE bubble cycle between frames.
- Writer accepts one sample per cycle, so it never back-pressures the ADC. The ADC rate is at most one per 17 BCLK.
- `o_overflow` is registered and asserts the cycle after the dropped strobe.

## Structure
- Shared package `visuaudio_pkg` holds `sample_t` (logic signed [15:0]), the reader state enum {R_IDLE, R_STREAM}, and the `abs_sat16` function.
- Sub-module `frame_bank`: one bank's storage, write port, combinational read, and peak tracker. Instantiate it twice. Bank selection, `full` flags, and the FSM stay in the top module.

## Test plan
All scenarios use FRAME_LEN=4.
- Reset release, samples 1,-2,3,-4 strobed, `i_rd_ready`=1 → `o_rd_valid` rises two edges after the 4th write. Stream 1,-2,3,-4 with `o_rd_last` on -4 and `o_rd_peak`=4.
- Sample -32768 in a frame of 0s → `o_rd_peak`=32767, and `o_rd_data` shows 16'h8000 unchanged.
- `i_rd_ready`=0, 12 samples strobed → first 8 stored (two frames), last 4 dropped, 4 `o_overflow` pulses, `o_drop_cnt`=4.
- Ready toggled 1/0 every cycle mid-frame → data and last held while stalled; the sequence is intact with no duplicates.
- Bank A's final read and bank B's final write in the same cycle → both frames stream back-to-back, bank A refills, and no drops occur.
- `i_rst_n` pulsed low mid-stream after 2 reads → all outputs go to reset values immediately. The next 4 samples form a fresh frame whose peak ignores pre-reset data.
